// File: rtl/pll_lock_supervisor.sv
// rtl/pll_lock_supervisor.sv - PLL reset/lock sequencer holding system reset until lock is stable
module pll_lock_supervisor #(
    parameter int RST_PULSE_CYCLES    = 16,
    parameter int LOCK_TIMEOUT_CYCLES = 50000,
    parameter int LOCK_STABLE_CYCLES  = 1024,
    parameter int MAX_RETRIES         = 3,
    parameter int CNT_W               = 16
) (
    input  logic       refclk,
    input  logic       rst,
    input  logic       pll_locked,
    input  logic       clear_fault,
    output logic       pll_rst,
    output logic       sys_rst,
    output logic       ready,
    output logic       fault,
    output logic [1:0] retry_count,
    output logic [7:0] lock_loss_count
);

    typedef enum logic [2:0] {
        S_PLL_RESET,
        S_WAIT_LOCK,
        S_STABILIZE,
        S_RUN,
        S_FAULT
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [CNT_W-1:0]  cnt_nxt;
    logic [1:0]        retry_nxt;
    logic [7:0]        loss_nxt;
    logic              locked_meta;
    logic              locked_s;

    localparam logic [CNT_W-1:0] PULSE_LAST   = CNT_W'(RST_PULSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] TIMEOUT_LAST = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] STABLE_LAST  = CNT_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [1:0]       RETRY_MAX    = 2'(MAX_RETRIES);

    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            locked_meta <= 1'b0;
            locked_s    <= 1'b0;
        end else begin
            locked_meta <= pll_locked;
            locked_s    <= locked_meta;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retry_nxt = retry_count;
        loss_nxt  = lock_loss_count;
        unique case (state)
            S_PLL_RESET: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (cnt == PULSE_LAST) state_nxt = S_WAIT_LOCK;
            end
            S_WAIT_LOCK: begin
                cnt_nxt = cnt + CNT_W'(1);
                // A lock seen on the timeout cycle takes priority over the retry.
                if (locked_s) begin
                    state_nxt = S_STABILIZE;
                end else if (cnt == TIMEOUT_LAST) begin
                    if (retry_count == RETRY_MAX) begin
                        state_nxt = S_FAULT;
                    end else begin
                        retry_nxt = retry_count + 2'd1;
                        state_nxt = S_PLL_RESET;
                    end
                end
            end
            S_STABILIZE: begin
                cnt_nxt = cnt + CNT_W'(1);
                if (!locked_s) state_nxt = S_WAIT_LOCK;
                else if (cnt == STABLE_LAST) state_nxt = S_RUN;
            end
            S_RUN: begin
                if (!locked_s) begin
                    state_nxt = S_PLL_RESET;
                    retry_nxt = 2'd0;
                    if (lock_loss_count != 8'hFF) loss_nxt = lock_loss_count + 8'd1;
                end
            end
            S_FAULT: begin
                if (clear_fault) begin
                    state_nxt = S_PLL_RESET;
                    retry_nxt = 2'd0;
                end
            end
            default: state_nxt = S_PLL_RESET;
        endcase
        if (state_nxt != state) cnt_nxt = '0;
    end

    // Outputs are decoded from the next state so they change on the transition edge.
    always_ff @(posedge refclk or posedge rst) begin
        if (rst) begin
            state           <= S_PLL_RESET;
            cnt             <= '0;
            pll_rst         <= 1'b1;
            sys_rst         <= 1'b1;
            ready           <= 1'b0;
            fault           <= 1'b0;
            retry_count     <= 2'd0;
            lock_loss_count <= 8'd0;
        end else begin
            state           <= state_nxt;
            cnt             <= cnt_nxt;
            pll_rst         <= (state_nxt == S_PLL_RESET) || (state_nxt == S_FAULT);
            sys_rst         <= (state_nxt != S_RUN);
            ready           <= (state_nxt == S_RUN);
            fault           <= (state_nxt == S_FAULT);
            retry_count     <= retry_nxt;
            lock_loss_count <= loss_nxt;
        end
    end

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// tb/tb_pll_lock_supervisor.sv - scoreboard bench for pll_lock_supervisor
module tb_pll_lock_supervisor;

    logic       clk = 1'b0;
    logic       rst;
    logic       pll_locked;
    logic       clear_fault;
    logic       pll_rst;
    logic       sys_rst;
    logic       ready;
    logic       fault;
    logic [1:0] retry_count;
    logic [7:0] lock_loss_count;

    pll_lock_supervisor #(
        .RST_PULSE_CYCLES   (4),
        .LOCK_TIMEOUT_CYCLES(64),
        .LOCK_STABLE_CYCLES (16),
        .MAX_RETRIES        (2),
        .CNT_W              (16)
    ) dut (
        .refclk         (clk),
        .rst            (rst),
        .pll_locked     (pll_locked),
        .clear_fault    (clear_fault),
        .pll_rst        (pll_rst),
        .sys_rst        (sys_rst),
        .ready          (ready),
        .fault          (fault),
        .retry_count    (retry_count),
        .lock_loss_count(lock_loss_count)
    );

    always #5 clk = ~clk;

    localparam int SEL_PLL_RST = 0;
    localparam int SEL_SYS_RST = 1;
    localparam int SEL_READY   = 2;
    localparam int SEL_FAULT   = 3;
    localparam int SEL_RETRY   = 4;
    localparam int SEL_LOSS    = 5;

    typedef struct {
        int    cyc;
        int    sel;
        int    val;
        string name;
    } exp_t;

    exp_t q[$];
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    int   r, t0, t1, d;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic int actual(input int sel);
        case (sel)
            SEL_PLL_RST: return int'(pll_rst);
            SEL_SYS_RST: return int'(sys_rst);
            SEL_READY:   return int'(ready);
            SEL_FAULT:   return int'(fault);
            SEL_RETRY:   return int'(retry_count);
            default:     return int'(lock_loss_count);
        endcase
    endfunction

    exp_t m_e;
    int   m_act;
    always @(negedge clk) begin
        while (q.size() > 0 && q[0].cyc <= cyc) begin
            m_e   = q.pop_front();
            m_act = actual(m_e.sel);
            checks++;
            if (m_act !== m_e.val) begin
                failures++;
                $display("FAIL %s cyc=%0d actual=%0d required=%0d", m_e.name, cyc, m_act, m_e.val);
            end
        end
    end

    task automatic push_at(input int at, input int sel, input int val, input string name);
        exp_t e;
        int   i;
        e.cyc = at; e.sel = sel; e.val = val; e.name = name;
        i = 0;
        while (i < q.size() && q[i].cyc <= at) i++;
        q.insert(i, e);
    endtask

    task automatic push_reset_vals(input int at, input string tag);
        push_at(at, SEL_PLL_RST, 1, {tag, "_pll_rst"});
        push_at(at, SEL_SYS_RST, 1, {tag, "_sys_rst"});
        push_at(at, SEL_READY,   0, {tag, "_ready"});
        push_at(at, SEL_FAULT,   0, {tag, "_fault"});
        push_at(at, SEL_RETRY,   0, {tag, "_retry"});
        push_at(at, SEL_LOSS,    0, {tag, "_loss"});
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_until(input int at);
        while (cyc < at) tick();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        pll_locked = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        r = cyc;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog cyc=%0d actual=running required=finished", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        pll_locked = 1'b0;
        clear_fault = 1'b0;

        // 1: reset state and normal bring-up
        tick();
        tick();
        push_reset_vals(cyc, "reset");
        rst = 1'b0;
        r = cyc;
        push_at(r + 3, SEL_PLL_RST, 1, "t1_pulse_last");
        push_at(r + 4, SEL_PLL_RST, 0, "t1_pulse_end");
        push_at(r + 7, SEL_PLL_RST, 0, "t1_clear_ignored");
        wait_until(r + 6);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        wait_until(r + 10);
        pll_locked = 1'b1;
        t0 = cyc;
        push_at(t0 + 18, SEL_SYS_RST, 1, "t1_sys_rst_held");
        push_at(t0 + 18, SEL_READY,   0, "t1_ready_low");
        push_at(t0 + 19, SEL_SYS_RST, 0, "t1_sys_rst_release");
        push_at(t0 + 19, SEL_READY,   1, "t1_ready");
        push_at(t0 + 19, SEL_RETRY,   0, "t1_retry");
        wait_until(t0 + 22);

        // 2: never locks, retries, fault, clear
        do_reset();
        push_at(r + 67,  SEL_PLL_RST, 0, "t2_wait1_end");
        push_at(r + 68,  SEL_PLL_RST, 1, "t2_pulse2_start");
        push_at(r + 68,  SEL_RETRY,   1, "t2_retry1");
        push_at(r + 71,  SEL_PLL_RST, 1, "t2_pulse2_last");
        push_at(r + 72,  SEL_PLL_RST, 0, "t2_pulse2_end");
        push_at(r + 136, SEL_PLL_RST, 1, "t2_pulse3_start");
        push_at(r + 136, SEL_RETRY,   2, "t2_retry2");
        push_at(r + 203, SEL_FAULT,   0, "t2_pre_fault");
        push_at(r + 204, SEL_FAULT,   1, "t2_fault");
        push_at(r + 204, SEL_PLL_RST, 1, "t2_fault_pll_rst");
        push_at(r + 204, SEL_SYS_RST, 1, "t2_fault_sys_rst");
        push_at(r + 250, SEL_RETRY,   2, "t2_fault_retry");
        push_at(r + 250, SEL_FAULT,   1, "t2_fault_held");
        wait_until(r + 250);
        push_at(r + 251, SEL_FAULT,   0, "t2_cleared");
        push_at(r + 251, SEL_RETRY,   0, "t2_retry_cleared");
        push_at(r + 254, SEL_PLL_RST, 1, "t2_new_pulse_last");
        push_at(r + 255, SEL_PLL_RST, 0, "t2_new_pulse_end");
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        wait_until(r + 256);

        // 3: glitch during STABILIZE
        do_reset();
        wait_until(r + 10);
        pll_locked = 1'b1;
        t0 = cyc;
        push_at(t0 + 19, SEL_SYS_RST, 1, "t3_no_early_release");
        wait_until(t0 + 8);
        pll_locked = 1'b0;
        wait_until(t0 + 11);
        pll_locked = 1'b1;
        t1 = cyc;
        push_at(t1 + 18, SEL_SYS_RST, 1, "t3_sys_rst_held");
        push_at(t1 + 19, SEL_SYS_RST, 0, "t3_release");
        push_at(t1 + 19, SEL_READY,   1, "t3_ready");
        push_at(t1 + 19, SEL_RETRY,   0, "t3_retry");
        wait_until(t1 + 20);

        // 4: lock loss in RUN, saturating loss counter
        for (int i = 1; i <= 260; i++) begin
            d = cyc;
            pll_locked = 1'b0;
            if (i == 1) begin
                push_at(d + 2, SEL_SYS_RST, 0, "t4_still_run");
                push_at(d + 2, SEL_READY,   1, "t4_ready_before");
                push_at(d + 3, SEL_SYS_RST, 1, "t4_sys_rst");
                push_at(d + 3, SEL_READY,   0, "t4_ready_drop");
                push_at(d + 3, SEL_PLL_RST, 1, "t4_pulse_start");
                push_at(d + 3, SEL_RETRY,   0, "t4_retry");
                push_at(d + 6, SEL_PLL_RST, 1, "t4_pulse_last");
                push_at(d + 7, SEL_PLL_RST, 0, "t4_pulse_end");
            end
            push_at(d + 3, SEL_LOSS, (i > 255) ? 255 : i, "t4_loss_count");
            wait_until(d + 10);
            pll_locked = 1'b1;
            if (i == 1 || i == 260) push_at(d + 29, SEL_READY, 1, "t4_run_again");
            wait_until(d + 32);
        end

        // 6a: async reset mid-STABILIZE
        d = cyc;
        pll_locked = 1'b0;
        wait_until(d + 10);
        pll_locked = 1'b1;
        t0 = cyc;
        push_at(t0 + 7, SEL_PLL_RST, 0, "t6a_pre_pll_rst");
        wait_until(t0 + 8);
        rst = 1'b1;
        push_reset_vals(cyc, "t6a_async");
        do_reset();
        wait_until(r + 10);
        pll_locked = 1'b1;
        t0 = cyc;
        push_at(t0 + 19, SEL_READY, 1, "t6a_resume_ready");
        push_at(t0 + 19, SEL_LOSS,  0, "t6a_resume_loss");
        wait_until(t0 + 20);

        // 5: lock arriving on the timeout cycle
        do_reset();
        wait_until(r + 65);
        pll_locked = 1'b1;
        push_at(r + 67, SEL_PLL_RST, 0, "t5_wait_end");
        push_at(r + 68, SEL_PLL_RST, 0, "t5_no_retry_pulse");
        push_at(r + 68, SEL_RETRY,   0, "t5_retry");
        push_at(r + 84, SEL_SYS_RST, 0, "t5_release");
        push_at(r + 84, SEL_READY,   1, "t5_ready");
        wait_until(r + 86);

        // 6b: async reset mid-FAULT
        do_reset();
        push_at(r + 205, SEL_FAULT, 1, "t6b_in_fault");
        push_at(r + 205, SEL_RETRY, 2, "t6b_retry");
        wait_until(r + 210);
        rst = 1'b1;
        push_reset_vals(cyc, "t6b_async");
        do_reset();
        push_at(r + 4, SEL_PLL_RST, 0, "t6b_resume_pulse_end");
        wait_until(r + 10);
        pll_locked = 1'b1;
        t0 = cyc;
        push_at(t0 + 19, SEL_READY, 1, "t6b_resume_ready");
        wait_until(t0 + 21);

        tick();
        tick();
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL drain pending=%0d required=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pll_lock_supervisor.md
Name: pll_lock_supervisor

Overview:
Controls the far end of the PLL's reset/locked interface, in the refclk domain. Drives the PLL reset input and watches its locked output. Holds the system reset until lock has been stable for a programmable time. Retries the PLL on lock timeout, enters a latched fault state after repeated failures, and re-sequences automatically when lock is lost in operation.

Parameters:
RST_PULSE_CYCLES, 16, width of each pll_rst pulse in refclk cycles (>=1)
LOCK_TIMEOUT_CYCLES, 50000, cycles allowed in WAIT_LOCK before a retry (1 ms at 50 MHz)
LOCK_STABLE_CYCLES, 1024, consecutive locked cycles required before releasing sys_rst (>=1)
MAX_RETRIES, 3, retries after the first attempt before FAULT
CNT_W, 16, shared counter width; must hold max(all cycle parameters)

Ports:
refclk  input  1  reference clock, 50 MHz, the single clock of the block
rst  input  1  asynchronous, active-high reset
pll_locked  input  1  PLL locked; asynchronous to refclk, double-flop synchronized internally (locked_s)
clear_fault  input  1  single-cycle pulse; leaves FAULT, ignored in all other states
pll_rst  output  1  reset to the PLL, active-high
sys_rst  output  1  downstream system reset, active-high
ready  output  1  high only in RUN
fault  output  1  high only in FAULT
retry_count  output  2  retries used in the current bring-up
lock_loss_count  output  8  lock losses seen in RUN, saturating at 255

Behaviour:
- All outputs registered. rst asserted forces, without a clock: state=PLL_RESET, cnt=0, sync flops=0, pll_rst=1, sys_rst=1, ready=0, fault=0, retry_count=0, lock_loss_count=0. Applies mid-operation in any state.
- locked_s = pll_locked delayed by two refclk edges. The FSM uses only locked_s.
- States PLL_RESET, WAIT_LOCK, STABILIZE, RUN, FAULT. cnt clears on every state change.
- PLL_RESET: pll_rst=1, sys_rst=1. cnt increments each cycle. When cnt==RST_PULSE_CYCLES-1, go to WAIT_LOCK, so pll_rst is high exactly RST_PULSE_CYCLES cycles.
- WAIT_LOCK: pll_rst=0, sys_rst=1.
  - If locked_s=1, go to STABILIZE.
  - Otherwise cnt increments. At cnt==LOCK_TIMEOUT_CYCLES-1: if retry_count==MAX_RETRIES, go to FAULT; else retry_count+1 and go to PLL_RESET.
- STABILIZE: pll_rst=0, sys_rst=1.
  - If locked_s=0, go to WAIT_LOCK. Timeout cnt restarts; retry_count is unchanged.
  - Otherwise, at cnt==LOCK_STABLE_CYCLES-1, go to RUN; else cnt increments.
- Lock release timing: sys_rst falls on the (LOCK_STABLE_CYCLES+2)th refclk edge after the edge that first samples pll_locked=1.
- RUN: sys_rst=0, ready=1, pll_rst=0. If locked_s=0, then in the same transition:
  - go to PLL_RESET;
  - sys_rst=1, ready=0;
  - lock_loss_count+1, saturating at 255;
  - retry_count=0.
  sys_rst therefore rises 3 edges after pll_locked falls.
- FAULT: pll_rst=1 (held, PLL parked), sys_rst=1, fault=1; retry_count frozen. clear_fault=1 → PLL_RESET with retry_count=0 and fault=0 on the same edge.
- Simultaneous events:
  - rst dominates everything.
  - In WAIT_LOCK, locked_s=1 on the timeout cycle wins: go to STABILIZE, no retry.
  - clear_fault outside FAULT has no effect.
- Glitches on pll_locked shorter than one refclk period may be missed. This is acceptable; the stability window covers it.

Test Plan:
(Benches use RST_PULSE_CYCLES=4, LOCK_TIMEOUT_CYCLES=64, LOCK_STABLE_CYCLES=16, MAX_RETRIES=2.)
1. Normal bring-up: release rst, raise pll_locked 10 cycles later → pll_rst high exactly 4 cycles; sys_rst falls and ready rises 18 edges after pll_locked is first sampled; retry_count=0.
2. Never locks: pll_locked=0 → 3 pll_rst pulses of 4 cycles, separated by 64 low cycles; then fault=1 with pll_rst held 1, retry_count=2, sys_rst=1. Pulse clear_fault → fault=0, new 4-cycle pll_rst pulse, retry_count=0.
3. Glitch in STABILIZE: pll_locked high 8 cycles, low 3 cycles, high again → sys_rst stays 1; release happens 18 edges after the re-rise; retry_count unchanged.
4. Lock loss in RUN: drop pll_locked → sys_rst=1 and ready=0 on the 3rd edge; lock_loss_count=1; 4-cycle pll_rst pulse follows. Restore lock → RUN again. Repeat 260 times → lock_loss_count saturates at 255.
5. Lock on timeout boundary: raise pll_locked so locked_s=1 exactly at cnt=63 of WAIT_LOCK → STABILIZE entered, retry_count unchanged, no pll_rst pulse.
6. Async reset mid-STABILIZE and mid-FAULT: assert rst between clock edges → pll_rst=1, sys_rst=1, ready=0, fault=0 and both counters 0 immediately; normal sequence resumes after release.
